// File: rtl/morse_playback_if.sv
// Handshake/status bundle between the Morse storage/top level and the
// playback controller. The master drives storage content and control flags;
// the slave (the controller) drives keying and status.
interface morse_playback_if;
    logic [29:0] store_seqs;
    logic        storage_sent;
    logic        abort;
    logic        tone_out;
    logic        busy;
    logic        done;
    logic [1:0]  letter_idx;

    modport master (
        output store_seqs, storage_sent, abort,
        input  tone_out, busy, done, letter_idx
    );

    modport slave (
        input  store_seqs, storage_sent, abort,
        output tone_out, busy, done, letter_idx
    );
endinterface

// File: rtl/morse_playback_ctrl.sv
// Morse playback controller: snapshots the 30-bit storage word (three 10-bit
// letters, 2-bit symbols, MSB first) on the rising edge of storage_sent and
// keys it onto tone_out with standard unit timing (dot 1, dash 3, intra-letter
// gap 1, inter-letter gap 3 units).
module morse_playback_ctrl #(
    parameter int UNIT_CYCLES = 25000000,
    parameter int UNIT_W      = 25
) (
    input  logic             clk,
    input  logic             reset,
    morse_playback_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_MARK,
        S_SPACE,
        S_LGAP,
        S_DONE
    } state_t;

    localparam logic [UNIT_W-1:0] UNIT_LAST = UNIT_W'(UNIT_CYCLES - 1);

    state_t            state, state_nx;
    logic [29:0]       shadow, shadow_nx;
    logic              storage_sent_q;
    logic [UNIT_W-1:0] unit_cnt, unit_cnt_nx;
    logic [2:0]        unit_num, unit_num_nx;
    logic [2:0]        sym_idx, sym_idx_nx;
    logic [1:0]        letter_idx, letter_idx_nx;
    logic              mark_long, mark_long_nx;

    logic              start_edge;
    logic [9:0]        cur_letter;
    logic [2:0]        sym_next;
    logic [1:0]        next_pair;
    logic [1:0]        next_first;
    logic [2:0]        units_needed;
    logic              unit_last;
    logic              timer_done;

    // Select one 10-bit letter slot; slot 0 is the most significant.
    function automatic logic [9:0] letter_at(input logic [29:0] w, input logic [1:0] idx);
        case (idx)
            2'd0:    return w[29:20];
            2'd1:    return w[19:10];
            default: return w[9:0];
        endcase
    endfunction

    // Symbol pair idx of a letter; anything past the fifth symbol reads as end.
    function automatic logic [1:0] pair_at(input logic [9:0] letter, input logic [2:0] idx);
        case (idx)
            3'd0:    return letter[9:8];
            3'd1:    return letter[7:6];
            3'd2:    return letter[5:4];
            3'd3:    return letter[3:2];
            3'd4:    return letter[1:0];
            default: return 2'b11;
        endcase
    endfunction

    // First symbol pair of a letter slot (decides empty / dot / dash).
    function automatic logic [1:0] first_pair(input logic [29:0] w, input logic [1:0] idx);
        logic [9:0] l;
        l = letter_at(w, idx);
        return l[9:8];
    endfunction

    assign start_edge = bus.storage_sent & ~storage_sent_q;
    assign cur_letter = letter_at(shadow, letter_idx);
    assign sym_next   = sym_idx + 3'd1;
    assign next_pair  = pair_at(cur_letter, sym_next);
    assign next_first = first_pair(shadow, letter_idx + 2'd1);
    assign unit_last  = (unit_cnt == UNIT_LAST);
    assign timer_done = unit_last && (unit_num == units_needed - 3'd1);

    // Duration of the current timed state in units.
    always_comb begin
        units_needed = 3'd1;
        case (state)
            S_MARK:  units_needed = mark_long ? 3'd3 : 3'd1;
            S_LGAP:  units_needed = 3'd2;
            default: units_needed = 3'd1;
        endcase
    end

    // Next-state, symbol/letter walk and unit timer decode.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_nx      = state;
        shadow_nx     = shadow;
        sym_idx_nx    = sym_idx;
        letter_idx_nx = letter_idx;
        mark_long_nx  = mark_long;

        case (state)
            S_IDLE: begin
                if (start_edge) begin
                    shadow_nx     = bus.store_seqs;
                    letter_idx_nx = 2'd0;
                    sym_idx_nx    = 3'd0;
                    state_nx      = S_FETCH;
                end
            end
            S_FETCH: begin
                if (shadow[29]) begin
                    state_nx = S_DONE;
                end else begin
                    mark_long_nx = shadow[28];
                    state_nx     = S_MARK;
                end
            end
            S_MARK: begin
                if (timer_done) state_nx = S_SPACE;
            end
            S_SPACE: begin
                if (timer_done) begin
                    sym_idx_nx = sym_next;
                    if (sym_next == 3'd5 || next_pair[1]) begin
                        if (letter_idx == 2'd2 || next_first[1]) state_nx = S_DONE;
                        else                                     state_nx = S_LGAP;
                    end else begin
                        mark_long_nx = next_pair[0];
                        state_nx     = S_MARK;
                    end
                end
            end
            S_LGAP: begin
                if (timer_done) begin
                    letter_idx_nx = letter_idx + 2'd1;
                    sym_idx_nx    = 3'd0;
                    mark_long_nx  = next_first[0];
                    state_nx      = S_MARK;
                end
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase

        // Cancel wins over any progress once playback is under way.
        if (state != S_IDLE && bus.abort) state_nx = S_IDLE;

        // The unit timer restarts on every state entry.
        if (state_nx != state) begin
            unit_cnt_nx = '0;
            unit_num_nx = 3'd0;
        end else if (unit_last) begin
            unit_cnt_nx = '0;
            unit_num_nx = unit_num + 3'd1;
        end else begin
            unit_cnt_nx = unit_cnt + 1'b1;
            unit_num_nx = unit_num;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    // Datapath registers: snapshot, edge detector, timer and walk indices.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow         <= '1;
            storage_sent_q <= 1'b0;
            unit_cnt       <= '0;
            unit_num       <= 3'd0;
            sym_idx        <= 3'd0;
            letter_idx     <= 2'd0;
            mark_long      <= 1'b0;
        end else begin
            shadow         <= shadow_nx;
            storage_sent_q <= bus.storage_sent;
            unit_cnt       <= unit_cnt_nx;
            unit_num       <= unit_num_nx;
            sym_idx        <= sym_idx_nx;
            letter_idx     <= letter_idx_nx;
            mark_long      <= mark_long_nx;
        end
    end

    // Outputs decoded from the registered state only.
    assign bus.tone_out   = (state == S_MARK);
    assign bus.busy       = (state != S_IDLE);
    assign bus.done       = (state == S_DONE);
    assign bus.letter_idx = letter_idx;

endmodule

// File: tb/tb_morse_playback_ctrl.sv
// Self-checking bench for morse_playback_ctrl with a 4-cycle Morse unit.
module tb_morse_playback_ctrl;

    localparam int U = 4;

    localparam logic [9:0] L_S   = 10'b0000001111;
    localparam logic [9:0] L_O   = 10'b0101011111;
    localparam logic [9:0] L_E   = 10'b0011111111;
    localparam logic [9:0] L_T   = 10'b0111111111;
    localparam logic [9:0] L_A   = 10'b0001111111;
    localparam logic [9:0] L_X   = 10'h3FF;
    localparam logic [9:0] L_5   = 10'b0000000000;
    localparam logic [9:0] L_D10 = 10'b0010000000;
    localparam logic [9:0] L_E10 = 10'b1000000000;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    morse_playback_if bus ();

    morse_playback_ctrl #(.UNIT_CYCLES(U), .UNIT_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    typedef struct {
        string       name;
        logic [29:0] seqs;
        int          marks;
        int          high;
        int          done_at;
        int          max_letter;
    } vec_t;

    vec_t vecs[7];

    int cap_marks, cap_high, cap_done_at, cap_max_letter, cap_done_cnt;
    logic cap_busy_after, cap_done_after;
    int runs[$];

    // Start a playback and record the tone waveform until done (cycle k=1 is
    // the first cycle after the edge that samples storage_sent high).
    task automatic play(input logic [29:0] seqs, input int limit, input bit hold_high);
        logic prev, started;
        int run_len;
        cap_marks = 0; cap_high = 0; cap_done_at = -1; cap_max_letter = 0; cap_done_cnt = 0;
        cap_busy_after = 1'bx; cap_done_after = 1'bx;
        runs.delete();
        prev = 1'b0; started = 1'b0; run_len = 0;
        @(posedge clk); #1;
        bus.store_seqs   = seqs;
        bus.storage_sent = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= limit; k++) begin
            @(negedge clk);
            if (k == 1 && !hold_high) bus.storage_sent = 1'b0;
            if (k == 10) bus.store_seqs = '1;
            if (int'(bus.letter_idx) > cap_max_letter) cap_max_letter = int'(bus.letter_idx);
            if (bus.done) begin
                cap_done_cnt++;
                cap_done_at = k;
                if (started) runs.push_back(run_len);
                @(negedge clk);
                cap_busy_after = bus.busy;
                cap_done_after = bus.done;
                break;
            end
            if (bus.tone_out) cap_high++;
            if (bus.tone_out && !prev) cap_marks++;
            if (started) begin
                if (bus.tone_out == prev) run_len++;
                else begin
                    runs.push_back(run_len);
                    run_len = 1;
                end
            end else if (bus.tone_out) begin
                started = 1'b1;
                run_len = 1;
            end
            prev = bus.tone_out;
        end
    endtask

    int exp_runs[18] = '{4,4,4,4,4,12,12,4,12,4,12,12,4,4,4,4,4,4};

    initial begin
        int seen;

        vecs[0] = '{name:"sos",        seqs:{L_S, L_O, L_S},     marks:9, high:60, done_at:114, max_letter:2};
        vecs[1] = '{name:"empty",      seqs:{L_X, L_X, L_X},     marks:0, high:0,  done_at:2,   max_letter:0};
        vecs[2] = '{name:"early_stop", seqs:{L_S, L_X, L_S},     marks:3, high:12, done_at:26,  max_letter:0};
        vecs[3] = '{name:"five_sym",   seqs:{L_5, L_X, L_X},     marks:5, high:20, done_at:42,  max_letter:0};
        vecs[4] = '{name:"te_stop",    seqs:{L_T, L_E, L_X},     marks:2, high:16, done_at:34,  max_letter:1};
        vecs[5] = '{name:"end10",      seqs:{L_D10, L_T, L_E10}, marks:2, high:16, done_at:34,  max_letter:1};
        vecs[6] = '{name:"aaa",        seqs:{L_A, L_A, L_A},     marks:6, high:48, done_at:90,  max_letter:2};

        reset            = 1'b1;
        bus.store_seqs   = '0;
        bus.storage_sent = 1'b0;
        bus.abort        = 1'b0;
        #3;
        check("reset_tone", 32'(bus.tone_out), 0);
        check("reset_busy", 32'(bus.busy), 0);
        check("reset_done", 32'(bus.done), 0);
        check("reset_letter_idx", 32'(bus.letter_idx), 0);
        @(posedge clk); #1 reset = 1'b0;

        // Table-driven playbacks.
        for (int i = 0; i < 7; i++) begin
            play(vecs[i].seqs, 300, 1'b0);
            check({vecs[i].name, "_done_at"}, 32'(cap_done_at), 32'(vecs[i].done_at));
            check({vecs[i].name, "_marks"}, 32'(cap_marks), 32'(vecs[i].marks));
            check({vecs[i].name, "_high"}, 32'(cap_high), 32'(vecs[i].high));
            check({vecs[i].name, "_max_letter"}, 32'(cap_max_letter), 32'(vecs[i].max_letter));
            check({vecs[i].name, "_busy_after_done"}, 32'(cap_busy_after), 0);
            check({vecs[i].name, "_done_one_cycle"}, 32'(cap_done_after), 0);
            repeat (3) @(posedge clk);
        end

        // SOS exact mark/gap run lengths, including the trailing space.
        play({L_S, L_O, L_S}, 300, 1'b0);
        check("sos_run_count", 32'(runs.size()), 18);
        for (int i = 0; i < 18; i++) begin
            if (i < runs.size()) check($sformatf("sos_run%0d", i), 32'(runs[i]), 32'(exp_runs[i]));
        end

        // Abort during the second dash of O.
        @(posedge clk); #1;
        bus.store_seqs   = {L_O, L_X, L_X};
        bus.storage_sent = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 22; k++) begin
            @(negedge clk);
            if (k == 1) bus.storage_sent = 1'b0;
        end
        check("abort_tone_before", 32'(bus.tone_out), 1);
        bus.abort = 1'b1;
        @(negedge clk);
        check("abort_tone_after", 32'(bus.tone_out), 0);
        check("abort_busy_after", 32'(bus.busy), 0);
        bus.abort = 1'b0;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.done) seen++;
        end
        check("abort_no_done", 32'(seen), 0);
        play({L_O, L_X, L_X}, 300, 1'b0);
        check("restart_done_at", 32'(cap_done_at), 50);
        check("restart_marks", 32'(cap_marks), 3);
        check("restart_first_run", 32'(runs.size() > 0 ? runs[0] : -1), 12);

        // Start and abort in the same IDLE cycle: start wins.
        @(posedge clk); #1;
        bus.store_seqs   = {L_E, L_X, L_X};
        bus.storage_sent = 1'b1;
        bus.abort        = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("start_abort_busy", 32'(bus.busy), 1);
        bus.abort        = 1'b0;
        bus.storage_sent = 1'b0;
        @(negedge clk);
        check("start_abort_tone", 32'(bus.tone_out), 1);
        seen = 0;
        for (int k = 0; k < 50 && seen == 0; k++) begin
            @(negedge clk);
            if (bus.done) seen = 1;
        end
        check("start_abort_done_seen", 32'(seen), 1);
        repeat (3) @(posedge clk);

        // Asynchronous reset mid-MARK, then a held-high start that must not retrigger.
        @(posedge clk); #1;
        bus.store_seqs   = {L_S, L_S, L_S};
        bus.storage_sent = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (k == 1) bus.storage_sent = 1'b0;
        end
        check("reset_mid_tone_before", 32'(bus.tone_out), 1);
        #1 reset = 1'b1;
        #1;
        check("reset_mid_tone", 32'(bus.tone_out), 0);
        check("reset_mid_busy", 32'(bus.busy), 0);
        check("reset_mid_done", 32'(bus.done), 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        check("after_reset_idle", 32'(bus.busy), 0);
        play({L_E, L_X, L_X}, 100, 1'b1);
        check("held_done_at", 32'(cap_done_at), 10);
        check("held_marks", 32'(cap_marks), 1);
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.busy) seen++;
        end
        check("held_no_retrigger", 32'(seen), 0);
        bus.storage_sent = 1'b0;
        repeat (2) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
